// File: rtl/rom_fetch_ctrl.sv
// Fetch controller in front of the instruction ROM: checks alignment/range,
// issues a one-cycle ROM strobe, and returns the word (or an error) with a one-cycle ack.
module rom_fetch_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ROM_BYTES = 4096,
    parameter int TIMEOUT   = 8,
    parameter int TO_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              flush_i,
    output logic              ack_o,
    output logic [DATA_W-1:0] data_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              rom_ce_o,
    output logic              rom_we_o,
    input  logic [DATA_W-1:0] rom_data_i,
    input  logic              rom_ready_i
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ERR, S_DRAIN} state_t;

    localparam logic [1:0] CODE_OK    = 2'b00;
    localparam logic [1:0] CODE_ALIGN = 2'b01;
    localparam logic [1:0] CODE_RANGE = 2'b10;
    localparam logic [1:0] CODE_TMO   = 2'b11;

    state_t          state;
    logic [TO_W-1:0] cnt;
    logic [1:0]      pend_code;
    logic            timed_out;

    assign timed_out = (cnt == TO_W'(TIMEOUT - 1));
    assign rom_we_o  = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            pend_code  <= CODE_OK;
            ack_o      <= 1'b0;
            data_o     <= '0;
            err_o      <= 1'b0;
            err_code_o <= CODE_OK;
            busy_o     <= 1'b0;
            rom_addr_o <= '0;
            rom_ce_o   <= 1'b0;
        end else begin
            ack_o    <= 1'b0;
            rom_ce_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_i && !flush_i) begin
                        rom_addr_o <= addr_i;
                        busy_o     <= 1'b1;
                        if (addr_i[1:0] != 2'b00) begin
                            state     <= S_ERR;
                            pend_code <= CODE_ALIGN;
                        end else if (addr_i >= ADDR_W'(ROM_BYTES)) begin
                            state     <= S_ERR;
                            pend_code <= CODE_RANGE;
                        end else begin
                            state    <= S_ISSUE;
                            rom_ce_o <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= flush_i ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    // A flush arriving with the response (or timeout) just drops it
                    if (rom_ready_i || timed_out) begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                        if (!flush_i) begin
                            ack_o      <= 1'b1;
                            err_o      <= !rom_ready_i;
                            err_code_o <= rom_ready_i ? CODE_OK : CODE_TMO;
                            if (rom_ready_i) data_o <= rom_data_i;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (flush_i) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (rom_ready_i || timed_out) begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ERR: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                    if (!flush_i) begin
                        ack_o      <= 1'b1;
                        err_o      <= 1'b1;
                        err_code_o <= pend_code;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
